exec_scheduler: RTL and testbench

- Dispatch and writeback controller for the six-entry reservation station.
- Entries 0-2 are add/sub slots; entries 3-5 are mul/div slots.
- Picks ready entries and issues them to one non-pipelined add/sub unit and one non-pipelined mul/div unit, then times execution.
- Arbitrates the single common data bus (CDB) and returns the winning entry's tag, which frees that RS slot.

---
 rtl/exec_scheduler.sv | 178 +++++++++++++++++
 tb/tb_exec_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_scheduler.sv
// Dispatch and writeback controller for a six-entry reservation station.
// Entries 0-2 feed one non-pipelined add/sub unit and entries 3-5 feed one
// non-pipelined mul/div unit. Each unit times its execution, then both units
// compete for the single common data bus, whose broadcast frees the RS slot.
module exec_scheduler #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 6
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [5:0]  rsBusy,
  input  logic [5:0]  rsReady,
  input  logic [17:0] rsOp,
  output logic        issueAS,
  output logic [2:0]  issueASTag,
  output logic        issueMD,
  output logic [2:0]  issueMDTag,
  output logic        cdbValid,
  output logic [2:0]  cdbTag,
  output logic [5:0]  rsFree,
  output logic [1:0]  fuBusy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic GRANT_AS = 1'b0;
  localparam logic GRANT_MD = 1'b1;

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                                               : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int CW = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] ADD_CNT = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  logic [1:0]    as_state, md_state;
  logic [CW-1:0] as_cnt, md_cnt;
  logic [2:0]    as_tag, md_tag;
  logic [5:0]    dispatched;
  logic          last_grant;

  logic [5:0]    cand;
  logic          as_hit, md_hit;
  logic [2:0]    as_idx, md_idx;
  logic [2:0]    md_op;
  logic [CW-1:0] md_lat;
  logic          as_issue, md_issue;
  logic          grant_as, grant_md;
  logic [5:0]    set_mask, clr_mask;
  logic          as_busy_nxt, md_busy_nxt;

  // The add/sub unit always runs ADD_LAT, so its opcode bits are never consulted.
  logic unused_as_op;
  assign unused_as_op = ^rsOp[8:0];

  // Candidate selection: lowest-index ready, undispatched entry in each group.
  always_comb begin
    cand   = rsBusy & rsReady & ~dispatched;
    as_hit = 1'b0;
    as_idx = 3'd0;
    md_hit = 1'b0;
    md_idx = 3'd0;
    md_op  = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      if (cand[i]) begin
        as_hit = 1'b1;
        as_idx = 3'(i);
      end
    end
    for (int i = 5; i >= 3; i--) begin
      if (cand[i]) begin
        md_hit = 1'b1;
        md_idx = 3'(i);
        md_op  = rsOp[3*i +: 3];
      end
    end
    md_lat = (md_op == 3'b010) ? MUL_CNT : DIV_CNT;
  end

  // Issue decisions, CDB arbitration and the dispatched-mask updates they imply.
  always_comb begin
    as_issue = (as_state == IDLE) && as_hit;
    md_issue = (md_state == IDLE) && md_hit;
    grant_as = (as_state == WB) && ((md_state != WB) || (last_grant == GRANT_MD));
    grant_md = (md_state == WB) && !grant_as;
    set_mask = 6'd0;
    clr_mask = 6'd0;
    if (as_issue) set_mask = set_mask | (6'd1 << as_idx);
    if (md_issue) set_mask = set_mask | (6'd1 << md_idx);
    if (grant_as) clr_mask = 6'd1 << as_tag;
    if (grant_md) clr_mask = 6'd1 << md_tag;
    as_busy_nxt = as_issue || (as_state == EXEC) || ((as_state == WB) && !grant_as);
    md_busy_nxt = md_issue || (md_state == EXEC) || ((md_state == WB) && !grant_md);
  end

  // Add/sub unit FSM: issue, count down the execution latency, wait for the bus.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      as_state <= IDLE;
      as_cnt   <= '0;
      as_tag   <= 3'd0;
    end else begin
      case (as_state)
        IDLE: if (as_issue) begin
          as_state <= EXEC;
          as_tag   <= as_idx;
          as_cnt   <= ADD_CNT;
        end
        EXEC: if (as_cnt == '0) as_state <= WB;
              else as_cnt <= as_cnt - 1'b1;
        WB:   if (grant_as) as_state <= IDLE;
        default: as_state <= IDLE;
      endcase
    end
  end

  // Mul/div unit FSM: latency is chosen from the opcode sampled at issue.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      md_state <= IDLE;
      md_cnt   <= '0;
      md_tag   <= 3'd0;
    end else begin
      case (md_state)
        IDLE: if (md_issue) begin
          md_state <= EXEC;
          md_tag   <= md_idx;
          md_cnt   <= md_lat;
        end
        EXEC: if (md_cnt == '0) md_state <= WB;
              else md_cnt <= md_cnt - 1'b1;
        WB:   if (grant_md) md_state <= IDLE;
        default: md_state <= IDLE;
      endcase
    end
  end

  // Dispatched mask and round-robin memory of the last bus winner.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dispatched <= 6'd0;
      last_grant <= GRANT_MD;
    end else begin
      dispatched <= (dispatched | set_mask) & ~clr_mask;
      if (grant_as)      last_grant <= GRANT_AS;
      else if (grant_md) last_grant <= GRANT_MD;
    end
  end

  // Registered outputs: one-cycle issue and broadcast pulses plus unit status.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      issueAS    <= 1'b0;
      issueASTag <= 3'd0;
      issueMD    <= 1'b0;
      issueMDTag <= 3'd0;
      cdbValid   <= 1'b0;
      cdbTag     <= 3'd0;
      rsFree     <= 6'd0;
      fuBusy     <= 2'b00;
    end else begin
      issueAS  <= as_issue;
      issueMD  <= md_issue;
      cdbValid <= grant_as || grant_md;
      rsFree   <= clr_mask;
      fuBusy   <= {md_busy_nxt, as_busy_nxt};
      if (as_issue) issueASTag <= as_idx;
      if (md_issue) issueMDTag <= md_idx;
      if (grant_as)      cdbTag <= as_tag;
      else if (grant_md) cdbTag <= md_tag;
    end
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Directed self-checking bench for exec_scheduler with default latencies
// (ADD 2, MUL 4, DIV 6). Expected values are worked out by hand per scenario.
module tb_exec_scheduler;

  logic        Clock;
  logic        Resetn;
  logic [5:0]  rsBusy;
  logic [5:0]  rsReady;
  logic [17:0] rsOp;
  logic        issueAS;
  logic [2:0]  issueASTag;
  logic        issueMD;
  logic [2:0]  issueMDTag;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [5:0]  rsFree;
  logic [1:0]  fuBusy;

  int checks = 0;
  int errors = 0;

  exec_scheduler dut (
    .Clock(Clock), .Resetn(Resetn),
    .rsBusy(rsBusy), .rsReady(rsReady), .rsOp(rsOp),
    .issueAS(issueAS), .issueASTag(issueASTag),
    .issueMD(issueMD), .issueMDTag(issueMDTag),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .rsFree(rsFree),
    .fuBusy(fuBusy)
  );

  // Free-running 10-time-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the reservation-station view seen by the scheduler.
  task automatic applyStimulus(input logic [5:0] busy, input logic [5:0] ready, input logic [17:0] op);
    rsBusy  = busy;
    rsReady = ready;
    rsOp    = op;
  endtask

  // Advance one edge and settle just after it before sampling.
  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // Expect the broadcast on exactly the n-th edge from now, quiet before it.
  task automatic expectCdb(input string name, input int n, input logic [2:0] expTag, input logic [5:0] expFree);
    for (int i = 1; i < n; i++) begin
      nextCycle();
      checkOutput({name, "_quiet"}, {31'd0, cdbValid}, 32'd0);
    end
    nextCycle();
    checkOutput({name, "_valid"}, {31'd0, cdbValid}, 32'd1);
    checkOutput({name, "_tag"}, {29'd0, cdbTag}, {29'd0, expTag});
    checkOutput({name, "_free"}, {26'd0, rsFree}, {26'd0, expFree});
  endtask

  // Pull reset low between edges, check outputs, hold across one edge, release.
  task automatic doReset(input string name);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput({name, "_outs_zero"},
                {12'd0, issueAS, issueASTag, issueMD, issueMDTag, cdbValid, cdbTag, rsFree, fuBusy}, 32'd0);
    nextCycle();
    checkOutput({name, "_held_zero"},
                {12'd0, issueAS, issueASTag, issueMD, issueMDTag, cdbValid, cdbTag, rsFree, fuBusy}, 32'd0);
    #2;
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0;
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    #12;
    checkOutput("reset_outs",
                {12'd0, issueAS, issueASTag, issueMD, issueMDTag, cdbValid, cdbTag, rsFree, fuBusy}, 32'd0);
    Resetn = 1'b1;
    nextCycle();
    checkOutput("idle_no_issue", {30'd0, issueMD, issueAS}, 32'd0);

    $display("[TB] single ADD in entry 1");
    applyStimulus(6'b000010, 6'b000010, 18'd0);
    nextCycle();
    checkOutput("add_issue", {31'd0, issueAS}, 32'd1);
    checkOutput("add_issue_tag", {29'd0, issueASTag}, 32'd1);
    checkOutput("add_fubusy", {30'd0, fuBusy}, 32'd1);
    expectCdb("add", 3, 3'd1, 6'b000010);
    checkOutput("add_fubusy_after", {30'd0, fuBusy}, 32'd0);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();
    checkOutput("add_cdb_pulse_end", {31'd0, cdbValid}, 32'd0);

    $display("[TB] priority and bubble, entries 0 and 2");
    applyStimulus(6'b000101, 6'b000101, 18'd0);
    nextCycle();
    checkOutput("prio_issue", {31'd0, issueAS}, 32'd1);
    checkOutput("prio_first_tag", {29'd0, issueASTag}, 32'd0);
    expectCdb("prio0", 3, 3'd0, 6'b000001);
    checkOutput("bubble_no_issue", {31'd0, issueAS}, 32'd0);
    applyStimulus(6'b000100, 6'b000100, 18'd0);
    nextCycle();
    checkOutput("bubble_issue", {31'd0, issueAS}, 32'd1);
    checkOutput("bubble_tag", {29'd0, issueASTag}, 32'd2);
    expectCdb("prio2", 3, 3'd2, 6'b000100);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();

    $display("[TB] DIV in entry 4, MUL in entry 3");
    applyStimulus(6'b010000, 6'b010000, {3'b000, 3'b011, 3'b000, 9'd0});
    nextCycle();
    checkOutput("div_issue", {31'd0, issueMD}, 32'd1);
    checkOutput("div_issue_tag", {29'd0, issueMDTag}, 32'd4);
    checkOutput("div_fubusy", {30'd0, fuBusy}, 32'd2);
    expectCdb("div", 7, 3'd4, 6'b010000);
    applyStimulus(6'b001000, 6'b001000, {3'b000, 3'b000, 3'b010, 9'd0});
    nextCycle();
    checkOutput("mul_issue", {31'd0, issueMD}, 32'd1);
    checkOutput("mul_issue_tag", {29'd0, issueMDTag}, 32'd3);
    expectCdb("mul", 5, 3'd3, 6'b001000);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();

    $display("[TB] CDB contention after reset");
    doReset("pre_contention");
    applyStimulus(6'b001000, 6'b001000, {3'b000, 3'b000, 3'b010, 9'd0});
    nextCycle();
    checkOutput("tie1_mul_issue", {31'd0, issueMD}, 32'd1);
    nextCycle();
    applyStimulus(6'b001001, 6'b001001, {3'b000, 3'b000, 3'b010, 9'd0});
    nextCycle();
    checkOutput("tie1_add_issue", {31'd0, issueAS}, 32'd1);
    expectCdb("tie1_first", 3, 3'd0, 6'b000001);
    applyStimulus(6'b001000, 6'b001000, {3'b000, 3'b000, 3'b010, 9'd0});
    nextCycle();
    checkOutput("tie1_second_valid", {31'd0, cdbValid}, 32'd1);
    checkOutput("tie1_second_tag", {29'd0, cdbTag}, 32'd3);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();
    // A lone ADD win makes the add/sub unit the last grantee before the next tie.
    applyStimulus(6'b000010, 6'b000010, 18'd0);
    nextCycle();
    expectCdb("solo_add", 3, 3'd1, 6'b000010);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();
    applyStimulus(6'b010000, 6'b010000, {3'b000, 3'b010, 3'b000, 9'd0});
    nextCycle();
    checkOutput("tie2_mul_issue", {31'd0, issueMD}, 32'd1);
    nextCycle();
    applyStimulus(6'b010100, 6'b010100, {3'b000, 3'b010, 3'b000, 9'd0});
    nextCycle();
    checkOutput("tie2_add_issue", {31'd0, issueAS}, 32'd1);
    expectCdb("tie2_first", 3, 3'd4, 6'b010000);
    applyStimulus(6'b000100, 6'b000100, 18'd0);
    nextCycle();
    checkOutput("tie2_second_valid", {31'd0, cdbValid}, 32'd1);
    checkOutput("tie2_second_tag", {29'd0, cdbTag}, 32'd2);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();

    $display("[TB] entry 5 busy but not ready");
    applyStimulus(6'b100000, 6'b000000, {3'b011, 15'd0});
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("notready_no_issue", {31'd0, issueMD}, 32'd0);
    end
    applyStimulus(6'b100000, 6'b100000, {3'b011, 15'd0});
    nextCycle();
    checkOutput("ready_issue", {31'd0, issueMD}, 32'd1);
    checkOutput("ready_issue_tag", {29'd0, issueMDTag}, 32'd5);

    $display("[TB] asynchronous reset mid-EXEC");
    nextCycle();
    nextCycle();
    doReset("midexec");
    nextCycle();
    checkOutput("reissue", {31'd0, issueMD}, 32'd1);
    checkOutput("reissue_tag", {29'd0, issueMDTag}, 32'd5);
    expectCdb("reissue_div", 7, 3'd5, 6'b100000);
    applyStimulus(6'b000000, 6'b000000, 18'd0);
    nextCycle();
    checkOutput("final_idle", {30'd0, fuBusy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
